// File: rtl/cpu_pkg.sv
// Opcode map and instruction-field positions shared by the sequencer and the
// cpu datapath it feeds.
package cpu_pkg;

  localparam int IW = 16;

  localparam logic [3:0] OPC_INC   = 4'b0000;
  localparam logic [3:0] OPC_DEC   = 4'b0001;
  localparam logic [3:0] OPC_SUB   = 4'b0010;
  localparam logic [3:0] OPC_ADD   = 4'b0011;
  localparam logic [3:0] OPC_BZ    = 4'b0100;
  localparam logic [3:0] OPC_STORE = 4'b0101;
  localparam logic [3:0] OPC_LOAD  = 4'b0110;
  localparam logic [3:0] OPC_LAND  = 4'b0111;
  localparam logic [3:0] OPC_LOR   = 4'b1000;
  localparam logic [3:0] OPC_AND   = 4'b1001;
  localparam logic [3:0] OPC_OR    = 4'b1010;
  localparam logic [3:0] OPC_XNOR  = 4'b1011;
  localparam logic [3:0] OPC_ROR   = 4'b1100;
  localparam logic [3:0] OPC_ROL   = 4'b1101;
  localparam logic [3:0] OPC_IDLE  = 4'b1110;
  localparam logic [3:0] OPC_HALT  = 4'b1111;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int OP1_HI = 11;
  localparam int OP1_LO = 9;
  localparam int OP2_HI = 8;
  localparam int OP2_LO = 6;

endpackage

// File: rtl/prog_mem.sv
// Program memory: 2**AW words of 16 bits, synchronous write, registered read.
// The read register doubles as the sequencer's instruction register.
module prog_mem
  import cpu_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  localparam int DEPTH = 1 << AW;

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] rdata_q;

  // NOTE: the array and its read register have no reset; program contents must survive rst.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue stage for the cpu datapath: steps a program counter through
// prog_mem, issues one op per instruction and executes BZ and HALT locally.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int         AW      = 6,
  parameter logic [3:0] IDLE_OP = OPC_IDLE,
  parameter logic [3:0] BZ_OP   = OPC_BZ,
  parameter logic [3:0] HALT_OP = OPC_HALT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  input  logic          z_in,
  output logic [3:0]    op,
  output logic [2:0]    op1,
  output logic [2:0]    op2,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          z_q, z_d;

  logic [IW-1:0] ir;
  logic [3:0]    ir_opc;
  logic          mem_we;
  logic          fetch_en;

  // Loading is only safe while nothing is executing.
  assign mem_we   = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign fetch_en = (state_q == S_FETCH);

  prog_mem #(.AW(AW)) u_prog_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .re_i    (fetch_en),
    .raddr_i (pc_q),
    .rdata_o (ir)
  );

  assign ir_opc = ir[OPC_HI:OPC_LO];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    z_d     = z_q;
    op      = IDLE_OP;
    op1     = 3'd0;
    op2     = 3'd0;
    busy    = 1'b0;
    halted  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          z_d     = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        busy    = 1'b1;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        busy    = 1'b1;
        state_d = S_FETCH;
        if (ir_opc == HALT_OP) begin
          state_d = S_HALT;
        end else if (ir_opc == BZ_OP) begin
          // Branch on the Z captured from the most recent issued op.
          pc_d = z_q ? ir[AW-1:0] : pc_q + AW'(1);
        end else begin
          op   = ir_opc;
          op1  = ir[OP1_HI:OP1_LO];
          op2  = ir[OP2_HI:OP2_LO];
          z_d  = z_in;
          pc_d = pc_q + AW'(1);
        end
      end

      S_HALT: begin
        halted = 1'b1;
        if (start) begin
          pc_d    = '0;
          z_d     = 1'b0;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a long
// randomized run, all compared against a cycle-level program interpreter.
module tb_instr_sequencer;
  import cpu_pkg::*;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
  localparam int OW    = 12 + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [15:0]   prog_data = '0;
  logic          start = 1'b0;
  logic          z_in = 1'b0;
  logic [3:0]    op;
  logic [2:0]    op1, op2;
  logic [AW-1:0] pc;
  logic          busy, halted;

  int n_vec = 0;
  int n_err = 0;
  bit z_random = 1'b0;

  instr_sequencer #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .z_in      (z_in),
    .op        (op),
    .op1       (op1),
    .op2       (op2),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // Reference interpreter: program image, phase of the current instruction,
  // program counter, remembered Z and the instruction being executed.
  typedef enum int {P_IDLE, P_FETCH, P_EXEC, P_HALT} phase_e;
  logic [15:0]   m_mem [DEPTH];
  phase_e        m_phase = P_IDLE;
  logic [AW-1:0] m_pc = '0;
  logic          m_z = 1'b0;
  logic [15:0]   m_ir = '0;

  function automatic bit model_issues();
    return (m_phase == P_EXEC) && (m_ir[15:12] != 4'b0100) && (m_ir[15:12] != 4'b1111);
  endfunction

  function automatic logic [OW-1:0] model_out();
    logic [3:0] e_op;
    logic [2:0] e_a, e_b;
    e_op = 4'b1110;
    e_a  = 3'd0;
    e_b  = 3'd0;
    if (model_issues()) begin
      e_op = m_ir[15:12];
      e_a  = m_ir[11:9];
      e_b  = m_ir[8:6];
    end
    return {e_op, e_a, e_b, m_pc,
            1'((m_phase == P_FETCH) || (m_phase == P_EXEC)), 1'(m_phase == P_HALT)};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_phase = P_IDLE;
      m_pc    = '0;
      m_z     = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE, P_HALT: begin
          if (prog_we) m_mem[prog_addr] = prog_data;
          if (start) begin
            m_phase = P_FETCH;
            m_pc    = '0;
            m_z     = 1'b0;
          end
        end
        P_FETCH: begin
          m_ir    = m_mem[m_pc];
          m_phase = P_EXEC;
        end
        default: begin
          if (m_ir[15:12] == 4'b1111) begin
            m_phase = P_HALT;
          end else begin
            m_phase = P_FETCH;
            if (m_ir[15:12] == 4'b0100) begin
              m_pc = m_z ? m_ir[AW-1:0] : m_pc + 1'b1;
            end else begin
              m_z  = z_in;
              m_pc = m_pc + 1'b1;
            end
          end
        end
      endcase
    end
  endtask

  // Z stand-in for the cpu: SUB rX,rX yields zero, everything else non-zero.
  task automatic cycle();
    if (z_random) z_in = 1'($urandom_range(0, 1));
    else z_in = model_issues() && (m_ir[15:12] == 4'b0010) && (m_ir[11:9] == m_ir[8:6]);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    cycle();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      exp = model_out();
      n_vec++;
      if ({op, op1, op2, pc, busy, halted} !== {4'b1110, 3'd0, 3'd0, {AW{1'b0}}, 2'b00}) begin
        n_err++;
        $display("FAIL reset c%0d: got %h expected %h", c, {op, op1, op2, pc, busy, halted}, exp);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      exp = model_out();
      n_vec++;
      if ({op, op1, op2, pc, busy, halted} !== exp || busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_no_issue c%0d: got %h expected %h", c, {op, op1, op2, pc, busy, halted}, exp);
      end
    end
  endtask

  task automatic test_straight();
    logic [OW-1:0] exp;
    load(0, 16'h3280);
    load(1, 16'h0200);
    load(2, 16'hF000);
    pulse_start();
    for (int c = 1; c <= 9; c++) begin
      exp = model_out();
      n_vec++;
      if ({op, op1, op2, pc, busy, halted} !== exp) begin
        n_err++;
        $display("FAIL straight c%0d: got %h expected %h", c, {op, op1, op2, pc, busy, halted}, exp);
      end
      if (c == 2 || c == 4 || c == 7) begin
        n_vec++;
        if ((c == 2 && {op, op1, op2} !== {4'b0011, 3'd1, 3'd2}) ||
            (c == 4 && {op, op1} !== {4'b0000, 3'd1}) ||
            (c == 7 && {halted, pc} !== {1'b1, AW'(2)})) begin
          n_err++;
          $display("FAIL straight_fixed c%0d: got op=%h op1=%0d op2=%0d pc=%0d halted=%b", c, op, op1, op2, pc, halted);
        end
      end
      cycle();
    end
  endtask

  task automatic test_branch();
    logic [OW-1:0] exp;
    load(0, 16'h2000);
    load(1, 16'h4005);
    load(2, 16'h0200);
    load(3, 16'h0200);
    load(4, 16'h0200);
    load(5, 16'hF000);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) load(0, 16'h3240);
      pulse_start();
      for (int c = 1; c <= 14; c++) begin
        exp = model_out();
        n_vec++;
        if ({op, op1, op2, pc, busy, halted} !== exp) begin
          n_err++;
          $display("FAIL branch%0d c%0d: got %h expected %h", pass, c, {op, op1, op2, pc, busy, halted}, exp);
        end
        if (c == 5) begin
          n_vec++;
          if (pc !== ((pass == 0) ? AW'(5) : AW'(2))) begin
            n_err++;
            $display("FAIL branch_target%0d: got pc=%0d expected %0d", pass, pc, (pass == 0) ? 5 : 2);
          end
        end
        cycle();
      end
      n_vec++;
      if ({halted, pc} !== {1'b1, AW'(5)}) begin
        n_err++;
        $display("FAIL branch_halt%0d: got halted=%b pc=%0d expected 1/5", pass, halted, pc);
      end
    end
  endtask

  task automatic test_wrap();
    logic [OW-1:0] exp;
    for (int a = 0; a < DEPTH; a++) load(a, 16'h0000);
    pulse_start();
    for (int c = 1; c <= 2 * DEPTH + 6; c++) begin
      exp = model_out();
      n_vec++;
      if ({op, op1, op2, pc, busy, halted} !== exp ||
          busy !== 1'b1 || pc !== AW'((c - 1) / 2)) begin
        n_err++;
        $display("FAIL wrap c%0d: got %h expected %h", c, {op, op1, op2, pc, busy, halted}, exp);
      end
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] exp;
    load(0, 16'h3280);
    load(1, 16'hF000);
    pulse_start();
    cycle();
    n_vec++;
    if ({op, op1, op2} !== {4'b0011, 3'd1, 3'd2}) begin
      n_err++;
      $display("FAIL rst_mid_issue: got op=%h op1=%0d op2=%0d expected 3/1/2", op, op1, op2);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_vec++;
    if ({op, op1, op2, pc, busy, halted} !== {4'b1110, 3'd0, 3'd0, {AW{1'b0}}, 2'b00}) begin
      n_err++;
      $display("FAIL rst_mid_drop: got %h expected %h", {op, op1, op2, pc, busy, halted}, model_out());
    end
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      exp = model_out();
      n_vec++;
      if ({op, op1, op2, pc, busy, halted} !== exp ||
          (c == 2 && op !== 4'b0011) || (c == 5 && halted !== 1'b1)) begin
        n_err++;
        $display("FAIL rst_mid_rerun c%0d: got %h expected %h", c, {op, op1, op2, pc, busy, halted}, exp);
      end
      cycle();
    end
  endtask

  task automatic test_lockout_restart();
    logic [OW-1:0] exp;
    load(0, 16'h0200);
    load(1, 16'h0200);
    load(2, 16'hF000);
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      prog_we   = (c <= 6);
      prog_addr = AW'(2);
      prog_data = 16'h0240;
      exp = model_out();
      n_vec++;
      if ({op, op1, op2, pc, busy, halted} !== exp ||
          (c == 7 && {halted, pc} !== {1'b1, AW'(2)})) begin
        n_err++;
        $display("FAIL lockout c%0d: got %h expected %h", c, {op, op1, op2, pc, busy, halted}, exp);
      end
      cycle();
    end
    prog_we = 1'b0;
    load(0, 16'h4003);
    load(1, 16'h2000);
    load(2, 16'hF000);
    load(3, 16'hF000);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      for (int c = 1; c <= 8; c++) begin
        exp = model_out();
        n_vec++;
        if ({op, op1, op2, pc, busy, halted} !== exp || (c == 3 && pc !== AW'(1))) begin
          n_err++;
          $display("FAIL restart%0d c%0d: got %h expected %h", pass, c, {op, op1, op2, pc, busy, halted}, exp);
        end
        cycle();
      end
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] exp;
    z_random = 1'b1;
    for (int a = 0; a < DEPTH; a++) load(a, 16'($urandom));
    for (int c = 0; c < 4000; c++) begin
      exp = model_out();
      n_vec++;
      if ({op, op1, op2, pc, busy, halted} !== exp) begin
        n_err++;
        $display("FAIL random c%0d: got %h expected %h", c, {op, op1, op2, pc, busy, halted}, exp);
      end
      rst       = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      prog_we   = !rst && ($urandom_range(0, 3) == 0);
      prog_addr = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
      prog_data = 16'($urandom);
      cycle();
    end
    rst      = 1'b0;
    start    = 1'b0;
    prog_we  = 1'b0;
    z_random = 1'b0;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_lockout_restart();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
